asyn_fifo_reader: RTL
=====================

# asyn_fifo_reader

Read-side consumer for the asynchronous FIFO, living entirely in the read clock domain. It pops words from the FIFO read port (`rdata`/`rempty`/`rinc`) and presents them downstream over a valid/ready stream through a 2-entry output buffer. It also keeps a running count of words popped, and supports a drain command that empties the FIFO and then reports completion. It is the counterpart to the write-side producer and is the block the read driver and read monitor observe in system-level runs.

## Interface
Parameters:
- `DSIZE`, default `` `DSIZE `` (8), data word width; must match the FIFO.
- `CNT_W`, default 16, width of the popped-word counter.

Ports:
- `rclk`  in  1  read-domain clock; all logic on posedge.
- `rrst_n`  in  1  reset. One clock; reset is synchronous and active-low.
- `en`  in  1  level; permits normal reading when high.
- `drain_req`  in  1  single-cycle pulse; start a drain.
- `rempty`  in  1  FIFO empty flag (read domain).
- `rdata`  in  DSIZE  FIFO head word; valid whenever `rempty`=0.
- `rinc`  out  1  FIFO pop strobe.
- `out_data`  out  DSIZE  downstream data.
- `out_valid`  out  1  downstream valid.
- `out_ready`  in  1  downstream ready.
- `busy`  out  1  high when state≠IDLE or the output buffer is non-empty.
- `drain_done`  out  1  one-cycle pulse when a drain completes.
- `rd_count`  out  CNT_W  total words popped since reset; wraps.

## Operation
- States:
  - IDLE: `rinc`=0. `en`=1 → RUN. `drain_req`=1 → DRAIN (takes precedence over `en`).
  - RUN: `rinc` follows the pop rule. `en`=0 → IDLE. `drain_req`=1 → DRAIN.
  - DRAIN: reads regardless of `en`. Exits → DONE when `rempty`=1 and the output buffer holds 0 entries in the same cycle.
  - DONE: `drain_done`=1 for exactly one cycle → IDLE.
- `drain_req` received in DRAIN or DONE is ignored.
- Pop rule (combinational): `rinc` = (state∈{RUN,DRAIN}) & ~`rempty` & (occupancy < 2).
  - Occupancy is the registered value, with no same-cycle pop credit.
  - At occupancy 1 with a simultaneous push and pop, the stream still sustains one word per cycle.
- Capture: on an edge where `rinc`=1, `rdata` is written into the output buffer and `rd_count` increments by 1.
- `rd_count` wraps from 2^CNT_W−1 to 0.
- Output buffer:
  - 2 entries, FIFO order.
  - `out_valid` = occupancy≠0.
  - `out_data` is the oldest entry.
  - Pop when `out_valid` & `out_ready`.
  - Push and pop in the same cycle leave occupancy unchanged.
- Leaving RUN for IDLE does not flush the buffer; buffered words still stream out.
- Reset, including mid-operation:
  - State → IDLE, buffer emptied.
  - Buffered words are discarded; they are not returned to the FIFO.
  - `rd_count`=0. `rinc`, `out_valid`, `busy`, `drain_done` all 0. `out_data`=0.

## Timing
- `rinc` has zero latency from `rempty`/state: it is combinational, with no register.
- Pop-to-output latency is 1 cycle. A word popped at edge N has `out_valid`=1 after edge N, provided the buffer was empty.
- `out_data` and `out_valid` are registered and hold stable while `out_valid`=1 and `out_ready`=0 (AXI-style; no retraction).
- `drain_done` asserts the cycle after the DRAIN exit condition is met.
- `busy` is combinational from registered state and occupancy.
- Throughput is 1 word/cycle when `rempty`=0 and `out_ready`=1 continuously.
- Backpressure: with `out_ready`=0, at most 2 pops occur, then `rinc` holds 0.

## Structure
- Shared package `asyn_fifo_pkg`:
  - state enum typedef `rd_state_e` (IDLE, RUN, DRAIN, DONE);
  - localparam `OBUF_DEPTH`=2;
  - default `DSIZE` taken from `` `DSIZE ``.
- Sub-module `asyn_fifo_obuf`: the 2-entry valid/ready output buffer (push, pop, occupancy, data).
- Top-level FSM, pop rule and counter live in `asyn_fifo_reader`.

## Test plan
- Reset mid-stream: `rrst_n`=0 for 1 cycle while occupancy=2 → next cycle `out_valid`=0, `rd_count`=0, `rinc`=0, state IDLE.
- Streaming:
  - Stimulus: FIFO preloaded with 0x11,0x22,0x33; `en`=1; `out_ready`=1.
  - Response: `rinc` high 3 consecutive cycles; `out_data` 0x11,0x22,0x33 on consecutive cycles starting 1 cycle after the first pop; `rd_count`=3.
- Backpressure:
  - Stimulus: 5 words preloaded; `out_ready`=0.
  - Response: exactly 2 pops, `rinc` then 0, `out_data`=first word held stable.
  - Follow-up: raise `out_ready` → remaining 3 words delivered in order; `rd_count`=5.
- Drain:
  - Stimulus: `en`=0, 4 words preloaded, `drain_req` pulse.
  - Response: 4 pops; `drain_done` pulses once, 1 cycle after `rempty`=1 and the buffer is empty; `busy`=0 afterwards.
- Drain on an empty FIFO: `drain_req` with `rempty`=1 → DRAIN→DONE, `drain_done` 2 cycles after the pulse, `rinc` never asserted.
- Counter wrap: with `CNT_W`=4, pop 17 words → `rd_count` reads 1.

Source files
------------

// File: rtl/asyn_fifo_pkg.sv
// Shared definitions for the asynchronous FIFO read-side consumer:
// reader state encoding, output buffer depth and default word width.

`ifndef DSIZE
`define DSIZE 8
`endif

package asyn_fifo_pkg;

    // Default data width follows the FIFO build-wide setting.
    localparam int DSIZE_DEFAULT = `DSIZE;

    // Depth of the valid/ready output buffer between FIFO and downstream.
    localparam int OBUF_DEPTH = 2;

    // Reader control states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } rd_state_e;

    // Occupancy after one edge given accepted push/pop; push and pop together hold it.
    function automatic logic [1:0] obuf_occ_next(
        input logic [1:0] occ,
        input logic       push,
        input logic       pop
    );
        logic [1:0] nxt;
        case ({push, pop})
            2'b10:   nxt = occ + 2'd1;
            2'b01:   nxt = occ - 2'd1;
            default: nxt = occ;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/asyn_fifo_obuf.sv
// Two-entry valid/ready output buffer. Entries leave in arrival order;
// the head entry and the valid flag are registers so downstream sees
// stable data while it withholds ready.

module asyn_fifo_obuf
    import asyn_fifo_pkg::*;
#(
    parameter int DSIZE = DSIZE_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [DSIZE-1:0] push_data_i,
    input  logic             ready_i,
    output logic [DSIZE-1:0] data_o,
    output logic             valid_o,
    output logic [1:0]       occ_o
);

    logic [DSIZE-1:0] head_q;
    logic [DSIZE-1:0] head_d;
    logic [DSIZE-1:0] tail_q;
    logic [DSIZE-1:0] tail_d;
    logic [1:0]       occ_q;
    logic [1:0]       occ_d;
    logic             pop_s;
    logic             push_s;

    // Handshake decode and next head/tail/occupancy for the two-slot queue.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        pop_s  = (occ_q != 2'd0) & ready_i;
        // A full buffer only takes a new word when the head leaves this cycle.
        push_s = push_i & ((occ_q < 2'(OBUF_DEPTH)) | pop_s);

        case (occ_q)
            2'd0: begin
                if (push_s) begin
                    head_d = push_data_i;
                end else begin
                    head_d = head_q;
                end
            end
            2'd1: begin
                if (push_s && pop_s) begin
                    // Sole entry leaves, new word becomes head: one word per cycle.
                    head_d = push_data_i;
                end else if (push_s) begin
                    tail_d = push_data_i;
                end else begin
                    head_d = head_q;
                end
            end
            2'd2: begin
                if (pop_s) begin
                    head_d = tail_q;
                    if (push_s) begin
                        tail_d = push_data_i;
                    end else begin
                        tail_d = tail_q;
                    end
                end else begin
                    head_d = head_q;
                end
            end
            default: begin
                head_d = head_q;
                tail_d = tail_q;
            end
        endcase

        occ_d = obuf_occ_next(occ_q, push_s, pop_s);
    end

    // Buffer storage and occupancy; reset discards any held words.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q <= {DSIZE{1'b0}};
            tail_q <= {DSIZE{1'b0}};
            occ_q  <= 2'd0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

    assign data_o  = head_q;
    assign valid_o = (occ_q != 2'd0);
    assign occ_o   = occ_q;

endmodule

// File: rtl/asyn_fifo_reader.sv
// Read-domain consumer of the asynchronous FIFO. Pops words into a small
// output buffer feeding a valid/ready stream, counts popped words and
// handles a drain command that empties the FIFO and signals completion.

module asyn_fifo_reader
    import asyn_fifo_pkg::*;
#(
    parameter int DSIZE = DSIZE_DEFAULT,
    parameter int CNT_W = 16
) (
    input  logic             rclk,
    input  logic             rrst_n,
    input  logic             en,
    input  logic             drain_req,
    input  logic             rempty,
    input  logic [DSIZE-1:0] rdata,
    output logic             rinc,
    output logic [DSIZE-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             drain_done,
    output logic [CNT_W-1:0] rd_count
);

    rd_state_e        state_q;
    rd_state_e        state_d;
    logic [CNT_W-1:0] rd_count_q;
    logic [CNT_W-1:0] rd_count_d;
    logic [1:0]       occ_s;
    logic             reading_s;
    logic             rinc_s;

    // Next state, pop strobe and counter update from registered state and occupancy.
    always_comb begin
        state_d    = state_q;
        rd_count_d = rd_count_q;
        reading_s  = (state_q == RUN) | (state_q == DRAIN);
        // Occupancy is the registered value: no credit for a same-cycle downstream pop.
        rinc_s     = reading_s & ~rempty & (occ_s < 2'(OBUF_DEPTH));

        case (state_q)
            IDLE: begin
                if (drain_req) begin
                    state_d = DRAIN;
                end else if (en) begin
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (drain_req) begin
                    state_d = DRAIN;
                end else if (!en) begin
                    state_d = IDLE;
                end else begin
                    state_d = RUN;
                end
            end
            DRAIN: begin
                // Finished only once nothing is left upstream or in the buffer.
                if (rempty && (occ_s == 2'd0)) begin
                    state_d = DONE;
                end else begin
                    state_d = DRAIN;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (rinc_s) begin
            rd_count_d = rd_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            rd_count_d = rd_count_q;
        end
    end

    // State and popped-word counter registers.
    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            state_q    <= IDLE;
            rd_count_q <= {CNT_W{1'b0}};
        end else begin
            state_q    <= state_d;
            rd_count_q <= rd_count_d;
        end
    end

    asyn_fifo_obuf #(
        .DSIZE (DSIZE)
    ) u_obuf (
        .clk         (rclk),
        .rst_n       (rrst_n),
        .push_i      (rinc_s),
        .push_data_i (rdata),
        .ready_i     (out_ready),
        .data_o      (out_data),
        .valid_o     (out_valid),
        .occ_o       (occ_s)
    );

    assign rinc       = rinc_s;
    assign rd_count   = rd_count_q;
    assign drain_done = (state_q == DONE);
    assign busy       = (state_q != IDLE) | (occ_s != 2'd0);

endmodule
